// File: rtl/core_run_ctrl.sv
// Run sequencer for the accumulator core: parks the core in reset while the host owns dmem,
// then runs it until done or timeout and counts the execution cycles.
module core_run_ctrl #(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 8,
  parameter int          CYC_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              core_reset,
  input  logic              core_done,
  output logic              dm_sel,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_di,
  input  logic [DATA_W-1:0] dm_dout,
  output logic              busy,
  output logic              finished,
  output logic              timed_out,
  output logic [CYC_W-1:0]  cycles,
  output logic [1:0]        state_dbg
);

  // Host handshake: an access is accepted on any cycle where host_valid & host_ready;
  // host_ready is high only while the core is parked, and there is no backpressure otherwise.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CYC_W-1:0] TMO    = CYC_W'(TIMEOUT);
  localparam logic [CYC_W-1:0] TMO_M1 = CYC_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cycles_q, cycles_d;
  logic              finished_q, finished_d;
  logic              timed_out_q, timed_out_d;
  logic              core_reset_q, core_reset_d;
  logic              dm_sel_q, dm_sel_d;
  logic              busy_q, busy_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              host_acc;

  assign host_acc = host_valid & dm_sel_q;

  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    finished_d  = finished_q;
    timed_out_d = timed_out_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_ARM;
          cycles_d    = '0;
          finished_d  = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      S_ARM: state_d = S_RUN;
      S_RUN: begin
        if (core_done) begin
          state_d    = S_DONE;
          finished_d = 1'b1;
        end else if (cycles_q == TMO_M1) begin
          state_d     = S_DONE;
          cycles_d    = TMO;
          finished_d  = 1'b1;
          timed_out_d = 1'b1;
        end else begin
          cycles_d = cycles_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Control outputs are registered from the next state so they change with the state.
    core_reset_d = (state_d != S_RUN);
    dm_sel_d     = (state_d == S_IDLE) || (state_d == S_DONE);
    busy_d       = (state_d == S_ARM) || (state_d == S_RUN);

    rvalid_d = host_acc & ~host_we;
    rdata_d  = rvalid_d ? dm_dout : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cycles_q     <= '0;
      finished_q   <= 1'b0;
      timed_out_q  <= 1'b0;
      core_reset_q <= 1'b1;
      dm_sel_q     <= 1'b1;
      busy_q       <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cycles_q     <= cycles_d;
      finished_q   <= finished_d;
      timed_out_q  <= timed_out_d;
      core_reset_q <= core_reset_d;
      dm_sel_q     <= dm_sel_d;
      busy_q       <= busy_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign host_ready  = dm_sel_q;
  assign dm_sel      = dm_sel_q;
  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign timed_out   = timed_out_q;
  assign cycles      = cycles_q;
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
  assign state_dbg   = state_q;

  assign dm_we   = host_acc & host_we;
  assign dm_addr = dm_sel_q ? host_addr : '0;
  assign dm_di   = dm_sel_q ? host_wdata : '0;

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run-sequencer that wraps the single-cycle accumulator core and its data memory. Gives an external host exclusive dmem access while the core is parked, holds the core in reset, and releases it on start. Counts execution cycles until the core raises done or a timeout expires, then re-parks the core and hands dmem back to the host.

Parameters:
ADDR_W, 8, dmem address width
DATA_W, 8, dmem data width
CYC_W, 16, cycle counter width
TIMEOUT, 16'hFFFF, max RUN cycles before forced stop (must be >= 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request a run; accepted only in IDLE or DONE
host_valid  input  1  host dmem access request
host_ready  output  1  host access accepted this cycle when host_valid & host_ready
host_we  input  1  1=write, 0=read
host_addr  input  ADDR_W  host dmem address
host_wdata  input  DATA_W  host write data
host_rdata  output  DATA_W  captured read data
host_rvalid  output  1  one-cycle pulse, host_rdata valid
core_reset  output  1  drives core reset (PC/carry)
core_done  input  1  core done flag
dm_sel  output  1  1=dmem driven by this block, 0=by core
dm_we  output  1  dmem write enable (host side)
dm_addr  output  ADDR_W  dmem address (host side)
dm_di  output  DATA_W  dmem write data (host side)
dm_dout  input  DATA_W  dmem combinational read data
busy  output  1  high in ARM or RUN
finished  output  1  sticky: last run ended
timed_out  output  1  sticky: last run ended by timeout
cycles  output  CYC_W  RUN cycle count of current/last run

Behaviour:
- Reset values: state=IDLE, core_reset=1, dm_sel=1, host_ready=1, dm_we=0, host_rvalid=0, host_rdata=0, busy=0, finished=0, timed_out=0, cycles=0.
- States: IDLE, ARM, RUN, DONE (registered).
- IDLE/DONE: core_reset=1, dm_sel=1, host_ready=1. ARM/RUN: core_reset=0 only in RUN (1 in ARM); dm_sel=0 and host_ready=0 in both.
- Host path (combinational while host_ready=1): dm_addr=host_addr, dm_di=host_wdata, dm_we=host_valid & host_we. When host_ready=0: dm_we=0; dm_addr/dm_di=0.
- Host read: accepted read captures dm_dout into host_rdata at that clock edge; host_rvalid=1 for exactly the next cycle. Write gives no rvalid. Back-to-back accesses every cycle are legal; one access per cycle.
- start in IDLE/DONE -> ARM. Same edge: cycles<=0, finished<=0, timed_out<=0. A host access in the same cycle completes normally; its rvalid still pulses in ARM.
- start in ARM/RUN is ignored.
- ARM -> RUN unconditionally after 1 cycle; guarantees the core sees reset while dmem ownership switches.
- RUN, each cycle: if core_done=1 -> DONE, finished<=1, cycles unchanged. Else if cycles==TIMEOUT-1 -> cycles<=TIMEOUT, DONE, finished<=1, timed_out<=1. Else cycles<=cycles+1.
- So cycles = number of RUN cycles in which core_done was 0; no wrap, saturates at TIMEOUT.
- core_done is ignored outside RUN.
- DONE holds cycles/finished/timed_out until the next accepted start or reset.
- Async reset at any point, including mid-RUN: immediate return to IDLE with reset values; core_reset asserts asynchronously.

Test Plan:
- Reset then write 0x5A to addr 0x10, read addr 0x10 -> dm_we=1 on the write cycle; host_rvalid pulses 1 cycle after the read, host_rdata=0x5A.
- start pulse, core_done rises on 5th RUN cycle -> ARM for 1 cycle with core_reset=1; RUN for 5 cycles with dm_sel=0, host_ready=0; DONE with cycles=4, finished=1, timed_out=0, core_reset=1.
- TIMEOUT=8, core_done held 0 -> cycles reaches 8; DONE with timed_out=1; host_ready=1 after.
- start together with a host read in IDLE -> read completes (rvalid in ARM, correct data), state goes ARM; start pulses during RUN are ignored and cycles is not cleared.
- Assert reset in mid-RUN (cycles=3) -> same cycle core_reset=1, dm_sel=1; after release: IDLE, cycles=0, finished=0.
- Second start from DONE -> flags cleared on acceptance; new count starts from 0.
